// File: rtl/serial_pkg.sv
// Shared types and constants for the serial receiver slice.
// Build option: SERIAL_RX_PARITY_EN adds an even-parity bit after the data bits.
package serial_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 5208;
    localparam int unsigned DATA_BITS            = 8;
    localparam logic        IDLE_LEVEL           = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SERIAL_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with extra-MSB pointers; head is presented combinationally.
module byte_fifo
    import serial_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 sysclk,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] pop_data,
    output logic                 full,
    output logic                 empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push writes into.
    assign do_push = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer advance on accepted push/pop.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care while empty.
    always_ff @(posedge sysclk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/serial_rx.sv
// UART receiver (8N1, or 8E1 with SERIAL_RX_PARITY_EN) feeding a byte FIFO,
// with sticky frame/overflow (and parity) error flags.
module serial_rx
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic       serialIn,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overflow,
    input  logic       err_clr,
    output logic       busy
`ifdef SERIAL_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);
    localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_n;
    logic                 sync1;
    logic                 sync2;
    logic                 rx_prev;
    logic                 rx_fall;
    logic [CW-1:0]        cnt;
    logic                 bit_end;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 cnt_clr;
    logic                 shift_en;
    logic                 stop_ok;
    logic                 ferr_set;
    logic                 ovf_set;
    logic                 push_q;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
`ifdef SERIAL_RX_PARITY_EN
    logic                 perr_set;
    logic                 drop;
`endif

    // Edge detect needs the line previously high, so after a low stop bit
    // no new start is seen until the line has returned to idle.
    assign rx_fall = rx_prev && !sync2;
    assign bit_end = (cnt == CNT_LAST);
    assign busy    = (state != IDLE);

    // Two-flop synchronizer plus history flop for falling-edge detection.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= IDLE_LEVEL;
            sync2   <= IDLE_LEVEL;
            rx_prev <= IDLE_LEVEL;
        end else begin
            sync1   <= serialIn;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    // FSM state register.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_n  = state;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        stop_ok  = 1'b0;
        ferr_set = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        perr_set = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_fall) begin
                    state_n = START;
                    cnt_clr = 1'b1;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_clr = 1'b1;
                    state_n = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_idx == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    perr_set = (^shreg) ^ sync2;
                    state_n  = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    if (sync2) begin
`ifdef SERIAL_RX_PARITY_EN
                        stop_ok = !drop;
`else
                        stop_ok = 1'b1;
`endif
                    end else begin
                        ferr_set = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Bit timer, bit index, shift register and delayed push strobe.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            push_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            drop    <= 1'b0;
`endif
        end else begin
            if (state == IDLE || cnt_clr || bit_end) cnt <= '0;
            else                                     cnt <= cnt + 1'b1;
            if (state == START)  bit_idx <= '0;
            else if (shift_en)   bit_idx <= bit_idx + 1'b1;
            if (shift_en) shreg <= {sync2, shreg[DATA_BITS-1:1]};
            push_q <= stop_ok;
`ifdef SERIAL_RX_PARITY_EN
            if (state == START)  drop <= 1'b0;
            else if (perr_set)   drop <= 1'b1;
`endif
        end
    end

    assign pop     = rx_valid && rx_ready;
    assign ovf_set = push_q && fifo_full && !pop;

    // Sticky error flags; clear wins over a same-cycle set.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (err_clr)       frame_err <= 1'b0;
            else if (ferr_set) frame_err <= 1'b1;
            if (err_clr)       overflow  <= 1'b0;
            else if (ovf_set)  overflow  <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
            if (err_clr)       parity_err <= 1'b0;
            else if (perr_set) parity_err <= 1'b1;
`endif
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .push      (push_q),
        .push_data (shreg),
        .pop       (pop),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_valid = !fifo_empty;

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208: sysclk cycles per serial bit (9600 baud at 50 MHz).
REQ-002 Parameter FIFO_DEPTH, default 4: received-byte buffer entries, power of two, minimum 2.
REQ-003 sysclk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 serialIn  input  1  asynchronous UART line, idle high.
REQ-006 rx_data  output  8  byte at the FIFO head.
REQ-007 rx_valid  output  1  FIFO not empty.
REQ-008 rx_ready  input  1  consumer accepts the head byte.
REQ-009 frame_err  output  1  sticky flag: stop bit sampled low.
REQ-010 overflow  output  1  sticky flag: byte dropped because the FIFO was full.
REQ-011 err_clr  input  1  clears both sticky flags.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 serialIn SHALL pass through a 2-flop synchronizer before any use; the sampling latency is 2 cycles.
REQ-014 The FSM SHALL use the states IDLE, START, DATA, PARITY and STOP.
REQ-015 IDLE -> START on a synchronized falling edge; the bit counter is cleared at that edge.
REQ-016 START: at count CLKS_PER_BIT/2, a low line -> DATA and the counter is reset; a high line -> IDLE (false start, nothing stored).
REQ-017 DATA: 8 bits SHALL be sampled, LSB first, each after CLKS_PER_BIT cycles, at mid-bit.
REQ-018 After bit 7 the FSM SHALL go to PARITY when compiled in, otherwise to STOP.
REQ-019 STOP: the line is sampled at mid-bit, then the FSM returns to IDLE the same cycle, without waiting a full stop bit.
REQ-020 A high stop bit SHALL push the byte into the FIFO one cycle after the sample.
REQ-021 A low stop bit SHALL set frame_err, discard the byte, and make the FSM wait in IDLE for the line to go high before the next start bit is detected.
REQ-022 rx_data SHALL be the FIFO head when rx_valid=1, and 0 when the FIFO is empty.
REQ-023 A pop SHALL occur when rx_valid && rx_ready; the next head appears the following cycle.
REQ-024 rx_data SHALL stay stable while rx_valid=1 and rx_ready=0.
REQ-025 A push to a full FIFO SHALL be dropped and set overflow; a simultaneous pop makes room, so that push SHALL succeed.
REQ-026 A push to an empty FIFO SHALL make rx_valid=1 the next cycle; there is no bypass.
REQ-027 Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full means MSBs differ and the rest are equal.
REQ-028 The bit timer SHALL be a counter of width $clog2(CLKS_PER_BIT), wrapping to 0 at CLKS_PER_BIT-1.
REQ-029 err_clr SHALL take priority over a simultaneous flag set; the flag is cleared.

Reset
REQ-030 reset_n=0 SHALL immediately force: FSM=IDLE, FIFO empty, rx_valid=0, rx_data=0, frame_err=0, overflow=0, busy=0, synchronizer flops=1.
REQ-031 A reset asserted mid-frame SHALL abandon that frame.
REQ-032 After reset release, reception SHALL resume only on a fresh falling edge.

Configuration
REQ-033 Macro SERIAL_RX_PARITY_EN defined: one even-parity bit is received after DATA.
REQ-034 With SERIAL_RX_PARITY_EN defined, a parity mismatch SHALL discard the byte and set output parity_err (sticky, cleared by err_clr, reset 0).
REQ-035 SERIAL_RX_PARITY_EN undefined: the PARITY state and the parity_err port SHALL not exist, and frames are 8N1.

Structure
REQ-036 Package serial_pkg SHALL hold: the FSM state enum, the default CLKS_PER_BIT, and the UART constants (DATA_BITS=8, IDLE_LEVEL=1).
REQ-037 The buffer SHALL be the sub-module byte_fifo (sync, FIFO_DEPTH x 8, push/pop/full/empty), instantiated once.

Verification
REQ-038 Send 0x41 in 8N1 with rx_ready=1 -> rx_valid pulses one cycle with rx_data=0x41, about 9.5 bit times after the start edge; frame_err=0.
REQ-039 Low glitch of CLKS_PER_BIT/4 cycles on an idle line -> returns to IDLE, rx_valid stays 0, no flags set.
REQ-040 Send 0x55 with the stop bit forced low -> frame_err=1, FIFO empty; pulse err_clr -> frame_err=0.
REQ-041 rx_ready=0, send 0x01..0x05 -> FIFO holds 0x01..0x04, overflow=1; drain -> 0x01,0x02,0x03,0x04 in order.
REQ-042 Assert reset_n=0 during bit 3 of 0x7E, release, send 0x31 -> exactly one byte, 0x31.
REQ-043 With SERIAL_RX_PARITY_EN: send 0x03 with parity bit 1 -> parity_err=1, no byte; send 0x03 with parity bit 0 -> byte 0x03 accepted.
